// File: rtl/pc_fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: next-PC op codes, FSM states, reset PC.
package pc_fetch_seq_pkg;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_HOLD   = 2'b11
  } npc_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } fetch_state_e;

  localparam logic [29:0] RESET_PC_DEFAULT = 30'h0000_0C00;

endpackage

// File: rtl/pc_fetch_seq_npc.sv
// Next-PC unit: word-address arithmetic for sequential, branch and jump targets (mod 2^30).
import pc_fetch_seq_pkg::*;

module pc_fetch_seq_npc (
  input  npc_op_e     op,
  input  logic [29:0] base,
  input  logic [25:0] imm,
  output logic [29:0] npc
);

  always_comb begin
    npc = base;
    case (op)
      NPC_PLUS4:  npc = base + 30'd1;
      // Branch offset is relative to the branch itself, not to the following word.
      NPC_BRANCH: npc = base + {{14{imm[15]}}, imm[15:0]};
      // Top four word-address bits correspond to byte-address bits [31:28].
      NPC_JUMP:   npc = {base[29:26], imm};
      default:    npc = base;
    endcase
  end

endmodule

// File: rtl/pc_fetch_seq.sv
// Fetch sequencer: owns the PC, issues one IMEM fetch at a time, holds the word for decode,
// and applies execute-stage redirects through the next-PC unit.
import pc_fetch_seq_pkg::*;

module pc_fetch_seq #(
  parameter logic [29:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_op,
  input  logic [29:0] redirect_pc,
  input  logic [25:0] redirect_imm,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [29:0] inst_pc,
  input  logic        inst_ready
);

  fetch_state_e state;
  logic [29:0]  pc;
  logic         req_q;
  logic         valid_q;
  npc_op_e      npc_op;
  logic [29:0]  npc_base;
  logic [29:0]  npc;
  logic         redirect;

  // Redirects arriving while IDLE are ignored; the fetch loop has not started yet.
  assign redirect = redirect_valid && (state != S_IDLE);
  assign npc_op   = redirect_valid ? npc_op_e'(redirect_op) : NPC_PLUS4;
  assign npc_base = redirect_valid ? redirect_pc : pc;

  pc_fetch_seq_npc u_npc (
    .op   (npc_op),
    .base (npc_base),
    .imm  (redirect_imm),
    .npc  (npc)
  );

  assign imem_req   = req_q;
  assign imem_addr  = pc;
  // A redirect squashes the held word in the very cycle it arrives.
  assign inst_valid = valid_q && !redirect_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      if (redirect) pc <= npc;
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
        S_REQ: begin
          if (imem_gnt) begin
            req_q <= 1'b0;
            state <= redirect ? S_DRAIN : S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            if (imem_rvalid) begin
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else if (imem_rvalid) begin
            inst    <= imem_rdata;
            inst_pc <= pc;
            valid_q <= 1'b1;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (redirect || inst_ready) begin
            if (!redirect) pc <= npc;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) begin
            req_q <= 1'b1;
            state <= S_REQ;
          end
        end
        default: begin
          state   <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  rvalid_only_when_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (state == S_WAIT || state == S_DRAIN));

endmodule
